// File: rtl/bbpd_pkg.sv
// Shared types for the bang-bang phase detector: the per-sample Alexander
// vote and its signed numeric weight.
package bbpd_pkg;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    EARLY = 2'd1,
    LATE  = 2'd2
  } vote_t;

  // LATE pushes the loop forward (+1), EARLY pulls it back (-1).
  function automatic logic signed [1:0] vote_val(input vote_t v);
    case (v)
      LATE:    vote_val = 2'sb01;
      EARLY:   vote_val = 2'sb11;
      default: vote_val = 2'sb00;
    endcase
  endfunction

endpackage

// File: rtl/alex_pd.sv
// Alexander early/late classifier: remembers the last valid data sample and
// grades the current edge sample against the data transition around it.
module alex_pd
  import bbpd_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  in_valid,
  input  logic  data,
  input  logic  edg,
  output vote_t vote
);

  logic d_prev_q, d_prev_d;
  logic has_prev_q, has_prev_d;

  // Without a data transition the edge sample carries no phase information.
  always_comb begin
    vote       = NONE;
    d_prev_d   = d_prev_q;
    has_prev_d = has_prev_q;
    if (in_valid) begin
      d_prev_d   = data;
      has_prev_d = 1'b1;
      if (has_prev_q && (data != d_prev_q)) begin
        vote = (edg == data) ? LATE : EARLY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_prev_q   <= 1'b0;
      has_prev_q <= 1'b0;
    end else begin
      d_prev_q   <= d_prev_d;
      has_prev_q <= has_prev_d;
    end
  end

endmodule

// File: rtl/bbpd_decim.sv
// Bang-bang phase detector with majority-vote decimation: Alexander votes are
// summed over win_len+1 valid samples and one registered up/dn pulse results.
module bbpd_decim
  import bbpd_pkg::*;
#(
  parameter int WB = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          data,
  input  logic          edg,
  input  logic [WB-1:0] win_len,
  input  logic [WB-1:0] thresh,
  output logic          up,
  output logic          dn
);

  vote_t vote;

  logic        [WB-1:0] cnt_q, cnt_d;
  logic signed [WB+1:0] acc_q, acc_d;
  logic                 up_q, up_d;
  logic                 dn_q, dn_d;

  logic signed [1:0]    vote_w;
  logic signed [WB+1:0] sum;
  logic signed [WB+1:0] neg_sum;
  logic signed [WB+1:0] thresh_ext;
  logic                 win_close;

  alex_pd u_alex_pd (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .data     (data),
    .edg      (edg),
    .vote     (vote)
  );

  // The closing sample's vote is folded in before the threshold test, and
  // win_len is compared live so a shrunken window closes on the next sample.
  always_comb begin
    vote_w     = vote_val(vote);
    sum        = acc_q + {{WB{vote_w[1]}}, vote_w};
    neg_sum    = -sum;
    thresh_ext = $signed({2'b00, thresh});
    win_close  = in_valid && (cnt_q >= win_len);

    cnt_d = cnt_q;
    acc_d = acc_q;
    up_d  = 1'b0;
    dn_d  = 1'b0;
    if (win_close) begin
      cnt_d = '0;
      acc_d = '0;
      up_d  = (sum > 0) && (sum >= thresh_ext);
      dn_d  = (sum < 0) && (neg_sum >= thresh_ext);
    end else if (in_valid) begin
      cnt_d = cnt_q + WB'(1);
      acc_d = sum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      acc_q <= '0;
      up_q  <= 1'b0;
      dn_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      up_q  <= up_d;
      dn_q  <= dn_d;
    end
  end

  assign up = up_q;
  assign dn = dn_q;

endmodule
